// File: rtl/multicycle_controller_pkg.sv
// ============================================================================
// multicycle_controller_pkg: state encodings, opcode/funct/ALU codes, ctrl bundle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_controller_pkg;

   // State encodings (4-bit, 12 states used)
   localparam logic [3:0] FETCH    = 4'd0;
   localparam logic [3:0] DECODE   = 4'd1;
   localparam logic [3:0] MEMADR   = 4'd2;
   localparam logic [3:0] MEMREAD  = 4'd3;
   localparam logic [3:0] MEMWB    = 4'd4;
   localparam logic [3:0] MEMWRITE = 4'd5;
   localparam logic [3:0] EXECUTE  = 4'd6;
   localparam logic [3:0] ALUWB    = 4'd7;
   localparam logic [3:0] BRANCH   = 4'd8;
   localparam logic [3:0] ADDIEX   = 4'd9;
   localparam logic [3:0] ADDIWB   = 4'd10;
   localparam logic [3:0] JUMP     = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM4 = 2'b11;

   typedef struct packed {
      logic       mem_req;
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       pc_en;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_control;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
   } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_alu_decoder.sv
// ============================================================================
// alu_decoder: R-type Funct field to ALUControl; unknown Funct falls back to add
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder
   import multicycle_controller_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (funct)
         FUNCT_ADD: alu_control = ALU_ADD;
         FUNCT_SUB: alu_control = ALU_SUB;
         FUNCT_AND: alu_control = ALU_AND;
         FUNCT_OR:  alu_control = ALU_OR;
         FUNCT_SLT: alu_control = ALU_SLT;
         default:   alu_control = ALU_ADD;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// multicycle_controller: multicycle MIPS main control FSM with memory handshake.
// Optional retired-instruction counter enabled by macro INSTR_COUNT_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter int CNT_WIDTH   = 32,
   parameter int STATE_WIDTH = 4
)(
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [5:0]             Opcode,
   input  logic [5:0]             Funct,
   input  logic                   Zero,
   input  logic                   MemReady,
   output logic                   MemReq,
   output logic                   IorD,
   output logic                   MemWrite,
   output logic                   IRWrite,
   output logic                   PCEn,
   output logic [1:0]             PCSrc,
   output logic                   ALUSrcA,
   output logic [1:0]             ALUSrcB,
   output logic [2:0]             ALUControl,
   output logic                   RegDst,
   output logic                   MemtoReg,
   output logic                   RegWrite,
`ifdef INSTR_COUNT_EN
   output logic [CNT_WIDTH-1:0]   InstrCount,
`endif
   output logic [STATE_WIDTH-1:0] State
);

   logic [STATE_WIDTH-1:0] state;
   logic [STATE_WIDTH-1:0] next_state;
   logic [2:0]             funct_alu;
   ctrl_t                  ctrl;

   alu_decoder u_alu_decoder (
      .funct       (Funct),
      .alu_control (funct_alu)
   );

   // State register
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state <= FETCH;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = FETCH;
      case (state)
         FETCH:    next_state = MemReady ? DECODE : FETCH;
         DECODE: begin
            case (Opcode)
               OP_LW,
               OP_SW:    next_state = MEMADR;
               OP_RTYPE: next_state = EXECUTE;
               OP_BEQ:   next_state = BRANCH;
               OP_ADDI:  next_state = ADDIEX;
               OP_J:     next_state = JUMP;
               default:  next_state = FETCH;
            endcase
         end
         MEMADR:   next_state = (Opcode == OP_SW) ? MEMWRITE : MEMREAD;
         MEMREAD:  next_state = MemReady ? MEMWB : MEMREAD;
         MEMWB:    next_state = FETCH;
         MEMWRITE: next_state = MemReady ? FETCH : MEMWRITE;
         EXECUTE:  next_state = ALUWB;
         ALUWB:    next_state = FETCH;
         BRANCH:   next_state = FETCH;
         ADDIEX:   next_state = ADDIWB;
         ADDIWB:   next_state = FETCH;
         JUMP:     next_state = FETCH;
         default:  next_state = FETCH;
      endcase
   end

   // Output decode; only FETCH (MemReady) and BRANCH (Zero) look beyond State
   always_comb begin
      ctrl = '0;
      case (state)
         FETCH: begin
            ctrl.mem_req     = 1'b1;
            ctrl.alu_src_b   = SRCB_FOUR;
            ctrl.alu_control = ALU_ADD;
            ctrl.pc_src      = PCSRC_ALU;
            ctrl.ir_write    = MemReady;
            ctrl.pc_en       = MemReady;
         end
         DECODE: begin
            ctrl.alu_src_b   = SRCB_IMM4;
            ctrl.alu_control = ALU_ADD;
         end
         MEMADR: begin
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = SRCB_IMM;
            ctrl.alu_control = ALU_ADD;
         end
         MEMREAD: begin
            ctrl.mem_req = 1'b1;
            ctrl.iord    = 1'b1;
         end
         MEMWB: begin
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         MEMWRITE: begin
            ctrl.mem_req   = 1'b1;
            ctrl.iord      = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         EXECUTE: begin
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = SRCB_REG;
            ctrl.alu_control = funct_alu;
         end
         ALUWB: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         BRANCH: begin
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = SRCB_REG;
            ctrl.alu_control = ALU_SUB;
            ctrl.pc_src      = PCSRC_ALUOUT;
            ctrl.pc_en       = Zero;
         end
         ADDIEX: begin
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = SRCB_IMM;
            ctrl.alu_control = ALU_ADD;
         end
         ADDIWB: begin
            ctrl.reg_write = 1'b1;
         end
         JUMP: begin
            ctrl.pc_src = PCSRC_JUMP;
            ctrl.pc_en  = 1'b1;
         end
         default: ctrl = '0;
      endcase
      if (!RST) begin
         ctrl = '0;
      end
   end

   assign MemReq     = ctrl.mem_req;
   assign IorD       = ctrl.iord;
   assign MemWrite   = ctrl.mem_write;
   assign IRWrite    = ctrl.ir_write;
   assign PCEn       = ctrl.pc_en;
   assign PCSrc      = ctrl.pc_src;
   assign ALUSrcA    = ctrl.alu_src_a;
   assign ALUSrcB    = ctrl.alu_src_b;
   assign ALUControl = ctrl.alu_control;
   assign RegDst     = ctrl.reg_dst;
   assign MemtoReg   = ctrl.mem_to_reg;
   assign RegWrite   = ctrl.reg_write;
   assign State      = RST ? state : '0;

`ifdef INSTR_COUNT_EN
   logic [CNT_WIDTH-1:0] count;

   // An instruction retires on every edge that re-enters FETCH
   always_ff @(posedge CLK) begin
      if (!RST) begin
         count <= '0;
      end else if ((next_state == FETCH) && (state != FETCH)) begin
         count <= count + CNT_WIDTH'(1);
      end
   end

   assign InstrCount = RST ? count : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// tb_multicycle_controller: directed self-checking bench for the control FSM
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECUTE  = 4'd6;
   localparam logic [3:0] S_ALUWB    = 4'd7;
   localparam logic [3:0] S_BRANCH   = 4'd8;
   localparam logic [3:0] S_ADDIEX   = 4'd9;
   localparam logic [3:0] S_ADDIWB   = 4'd10;
   localparam logic [3:0] S_JUMP     = 4'd11;

   // {MemReq,IorD,MemWrite,IRWrite,PCEn}_PCSrc_ALUSrcA_ALUSrcB_ALUControl_{RegDst,MemtoReg,RegWrite}
   localparam logic [15:0] E_ZERO     = 16'b00000_00_0_00_000_000;
   localparam logic [15:0] E_FETCH_W  = 16'b10000_00_0_01_010_000;
   localparam logic [15:0] E_FETCH_R  = 16'b10011_00_0_01_010_000;
   localparam logic [15:0] E_DECODE   = 16'b00000_00_0_11_010_000;
   localparam logic [15:0] E_MEMADR   = 16'b00000_00_1_10_010_000;
   localparam logic [15:0] E_MEMREAD  = 16'b11000_00_0_00_000_000;
   localparam logic [15:0] E_MEMWB    = 16'b00000_00_0_00_000_011;
   localparam logic [15:0] E_MEMWRITE = 16'b11100_00_0_00_000_000;
   localparam logic [15:0] E_EXEC_SUB = 16'b00000_00_1_00_110_000;
   localparam logic [15:0] E_EXEC_ADD = 16'b00000_00_1_00_010_000;
   localparam logic [15:0] E_ALUWB    = 16'b00000_00_0_00_000_101;
   localparam logic [15:0] E_BR_T     = 16'b00001_01_1_00_110_000;
   localparam logic [15:0] E_BR_N     = 16'b00000_01_1_00_110_000;
   localparam logic [15:0] E_ADDIEX   = 16'b00000_00_1_10_010_000;
   localparam logic [15:0] E_ADDIWB   = 16'b00000_00_0_00_000_001;
   localparam logic [15:0] E_JUMP     = 16'b00001_10_0_00_000_000;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [5:0] Opcode = 6'd0;
   logic [5:0] Funct = 6'd0;
   logic       Zero = 1'b0;
   logic       MemReady = 1'b0;
   logic       MemReq, IorD, MemWrite, IRWrite, PCEn;
   logic [1:0] PCSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUControl;
   logic       RegDst, MemtoReg, RegWrite;
   logic [3:0] State;
`ifdef INSTR_COUNT_EN
   logic [3:0] InstrCount;
`endif
   logic [15:0] ctl;

   int n_assert = 0;
   int n_fail   = 0;

   multicycle_controller #(
      .CNT_WIDTH   (4),
      .STATE_WIDTH (4)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .Opcode     (Opcode),
      .Funct      (Funct),
      .Zero       (Zero),
      .MemReady   (MemReady),
      .MemReq     (MemReq),
      .IorD       (IorD),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .PCEn       (PCEn),
      .PCSrc      (PCSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUControl (ALUControl),
      .RegDst     (RegDst),
      .MemtoReg   (MemtoReg),
      .RegWrite   (RegWrite),
`ifdef INSTR_COUNT_EN
      .InstrCount (InstrCount),
`endif
      .State      (State)
   );

   always #5 CLK = ~CLK;

   assign ctl = {MemReq, IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA,
                 ALUSrcB, ALUControl, RegDst, MemtoReg, RegWrite};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check state and control word mid-cycle, then advance one clock edge
   task automatic cyc(input string tag, input logic [3:0] st, input logic [15:0] c);
      #1;
      chk({tag, ".state"}, 32'(State), 32'(st));
      chk({tag, ".ctl"}, 32'(ctl), 32'(c));
      @(posedge CLK);
      #1;
   endtask

   task automatic run_cycles(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   initial begin
      // Reset held low: all outputs forced to zero even with MemReady high
      RST = 1'b0;
      MemReady = 1'b1;
      Opcode = 6'b100011;
      @(posedge CLK);
      #1;
      chk("rst.ctl", 32'(ctl), 32'(E_ZERO));
      chk("rst.state", 32'(State), 32'(S_FETCH));
      RST = 1'b1;

      // lw, zero-wait memory: 5 cycles
      cyc("lw.fetch",   S_FETCH,   E_FETCH_R);
      cyc("lw.decode",  S_DECODE,  E_DECODE);
      cyc("lw.memadr",  S_MEMADR,  E_MEMADR);
      cyc("lw.memread", S_MEMREAD, E_MEMREAD);
      cyc("lw.memwb",   S_MEMWB,   E_MEMWB);

      // Fetch stalled three cycles
      MemReady = 1'b0;
      cyc("fw.wait0", S_FETCH, E_FETCH_W);
      cyc("fw.wait1", S_FETCH, E_FETCH_W);
      cyc("fw.wait2", S_FETCH, E_FETCH_W);
      MemReady = 1'b1;
      Opcode = 6'b000000;
      Funct  = 6'b100010;
      cyc("sub.fetch",  S_FETCH,   E_FETCH_R);
      cyc("sub.decode", S_DECODE,  E_DECODE);
      cyc("sub.exec",   S_EXECUTE, E_EXEC_SUB);
      cyc("sub.aluwb",  S_ALUWB,   E_ALUWB);

      // Unknown Funct defaults to add
      Funct = 6'b111111;
      cyc("fx.fetch",  S_FETCH,   E_FETCH_R);
      cyc("fx.decode", S_DECODE,  E_DECODE);
      cyc("fx.exec",   S_EXECUTE, E_EXEC_ADD);
      cyc("fx.aluwb",  S_ALUWB,   E_ALUWB);

      // beq taken, then not taken
      Opcode = 6'b000100;
      Zero = 1'b1;
      cyc("beqt.fetch",  S_FETCH,  E_FETCH_R);
      cyc("beqt.decode", S_DECODE, E_DECODE);
      cyc("beqt.branch", S_BRANCH, E_BR_T);
      Zero = 1'b0;
      cyc("beqn.fetch",  S_FETCH,  E_FETCH_R);
      cyc("beqn.decode", S_DECODE, E_DECODE);
      cyc("beqn.branch", S_BRANCH, E_BR_N);

      // sw stalled in MEMWRITE, aborted by reset
      Opcode = 6'b101011;
      cyc("swr.fetch",  S_FETCH,  E_FETCH_R);
      cyc("swr.decode", S_DECODE, E_DECODE);
      cyc("swr.memadr", S_MEMADR, E_MEMADR);
      MemReady = 1'b0;
      cyc("swr.memwr0", S_MEMWRITE, E_MEMWRITE);
      cyc("swr.memwr1", S_MEMWRITE, E_MEMWRITE);
      RST = 1'b0;
      #1;
      chk("swr.rstlow.ctl", 32'(ctl), 32'(E_ZERO));
      @(posedge CLK);
      #1;
      RST = 1'b1;
      cyc("swr.after", S_FETCH, E_FETCH_W);

      // Illegal opcode runs as a NOP
      MemReady = 1'b1;
      Opcode = 6'b111111;
      cyc("nop.fetch",  S_FETCH,  E_FETCH_R);
      cyc("nop.decode", S_DECODE, E_DECODE);
      MemReady = 1'b0;
      cyc("nop.back",   S_FETCH,  E_FETCH_W);

      // addi
      MemReady = 1'b1;
      Opcode = 6'b001000;
      cyc("addi.fetch",  S_FETCH,  E_FETCH_R);
      cyc("addi.decode", S_DECODE, E_DECODE);
      cyc("addi.ex",     S_ADDIEX, E_ADDIEX);
      cyc("addi.wb",     S_ADDIWB, E_ADDIWB);

      // j
      Opcode = 6'b000010;
      cyc("j.fetch",  S_FETCH,  E_FETCH_R);
      cyc("j.decode", S_DECODE, E_DECODE);
      cyc("j.jump",   S_JUMP,   E_JUMP);

      // sw completing with zero-wait memory
      Opcode = 6'b101011;
      cyc("sw.fetch",  S_FETCH,    E_FETCH_R);
      cyc("sw.decode", S_DECODE,   E_DECODE);
      cyc("sw.memadr", S_MEMADR,   E_MEMADR);
      cyc("sw.memwr",  S_MEMWRITE, E_MEMWRITE);
      cyc("sw.done",   S_FETCH,    E_FETCH_R);

`ifdef INSTR_COUNT_EN
      RST = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b1;
      MemReady = 1'b1;
      #1;
      chk("cnt.reset", 32'(InstrCount), 32'd0);
      Opcode = 6'b100011; run_cycles(5);
      Opcode = 6'b000000; Funct = 6'b100000; run_cycles(4);
      Opcode = 6'b000010; run_cycles(3);
      Opcode = 6'b000100; Zero = 1'b1; run_cycles(3);
      #1;
      chk("cnt.four", 32'(InstrCount), 32'd4);
      Opcode = 6'b111111;
      run_cycles(2 * 11);
      #1;
      chk("cnt.fifteen", 32'(InstrCount), 32'd15);
      run_cycles(2);
      #1;
      chk("cnt.wrap", 32'(InstrCount), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
